// File: rtl/branch_resolve_if.sv
// Bundle between the execute/fetch pipeline and the branch resolve unit.
// The pipeline side is the master; the resolve unit is the slave.
interface branch_resolve_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic [XLEN-1:0]  pred_pc;
  logic             pred_taken;
  logic             res_valid;
  logic [3:0]       res_ctl;
  logic [XLEN-1:0]  res_a;
  logic [XLEN-1:0]  res_b;
  logic [XLEN-1:0]  res_pc;
  logic [XLEN-1:0]  res_target;
  logic             res_pred_taken;
  logic             clr_stats;
  logic             flush;
  logic [XLEN-1:0]  redirect_pc;
  logic             br_taken;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mispred_count;

  modport master (
    output pred_pc, res_valid, res_ctl, res_a, res_b, res_pc, res_target,
           res_pred_taken, clr_stats,
    input  pred_taken, flush, redirect_pc, br_taken, br_count, mispred_count
  );

  modport slave (
    input  pred_pc, res_valid, res_ctl, res_a, res_b, res_pc, res_target,
           res_pred_taken, clr_stats,
    output pred_taken, flush, redirect_pc, br_taken, br_count, mispred_count
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver with a direct-mapped 2-bit counter predictor,
// registered mispredict flush/redirect and saturating statistics counters.
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 6,
  parameter int CNT_W = 32
) (
  input logic             clk,
  input logic             rst_n,
  branch_resolve_if.slave bif
);
  localparam int ENTRIES = 1 << IDX_W;

  localparam logic [3:0] CTL_BLT  = 4'b0111;
  localparam logic [3:0] CTL_BGE  = 4'b1011;
  localparam logic [3:0] CTL_BEQ  = 4'b1100;
  localparam logic [3:0] CTL_BNE  = 4'b1101;
  localparam logic [3:0] CTL_BLTU = 4'b1000;
  localparam logic [3:0] CTL_BGEU = 4'b1001;

  logic [1:0]       ctr_q [ENTRIES];
  logic [IDX_W-1:0] res_idx;
  logic [IDX_W-1:0] pred_idx;
  logic [1:0]       ctr_cur;
  logic [1:0]       ctr_nxt;

  logic             lt_s;
  logic             lt_u;
  logic             eq;
  logic             is_br;
  logic             taken;
  logic             eff;
  logic             mispred;

  logic [XLEN-1:0]  seq_pc;
  logic [XLEN-1:0]  redirect_nxt;

  logic             flush_q;
  logic             br_taken_q;
  logic [XLEN-1:0]  redirect_q;
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] mis_cnt_q;

  logic             unused_pred_pc;

  assign lt_s = $signed(bif.res_a) < $signed(bif.res_b);
  assign lt_u = bif.res_a < bif.res_b;
  assign eq   = bif.res_a == bif.res_b;

  always_comb begin
    is_br = 1'b1;
    taken = 1'b0;
    case (bif.res_ctl)
      CTL_BLT:  taken = lt_s;
      CTL_BGE:  taken = ~lt_s;
      CTL_BEQ:  taken = eq;
      CTL_BNE:  taken = ~eq;
      CTL_BLTU: taken = lt_u;
      CTL_BGEU: taken = ~lt_u;
      default: begin
        is_br = 1'b0;
        taken = 1'b0;
      end
    endcase
  end

  assign eff     = bif.res_valid & is_br;
  assign mispred = eff & (taken != bif.res_pred_taken);

  // pc[1:0] never selects an entry; instructions are word aligned
  assign res_idx  = bif.res_pc[IDX_W+1:2];
  assign pred_idx = bif.pred_pc[IDX_W+1:2];
  assign ctr_cur  = ctr_q[res_idx];

  always_comb begin
    ctr_nxt = ctr_cur;
    if (taken) begin
      if (ctr_cur != 2'b11) ctr_nxt = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'b00) ctr_nxt = ctr_cur - 2'd1;
    end
  end

  assign seq_pc       = bif.res_pc + XLEN'(4);
  assign redirect_nxt = taken ? bif.res_target : seq_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else if (eff) begin
      ctr_q[res_idx] <= ctr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_q    <= 1'b0;
      redirect_q <= '0;
      br_taken_q <= 1'b0;
    end else begin
      flush_q <= mispred;
      if (mispred) redirect_q <= redirect_nxt;
      if (eff)     br_taken_q <= taken;
    end
  end

  // clear wins over any same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else if (bif.clr_stats) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (eff && (br_cnt_q != '1))      br_cnt_q  <= br_cnt_q + CNT_W'(1);
      if (mispred && (mis_cnt_q != '1)) mis_cnt_q <= mis_cnt_q + CNT_W'(1);
    end
  end

  // prediction reads the current table with no bypass of a same-cycle update
  assign bif.pred_taken    = ctr_q[pred_idx][1];
  assign bif.flush         = flush_q;
  assign bif.redirect_pc   = redirect_q;
  assign bif.br_taken      = br_taken_q;
  assign bif.br_count      = br_cnt_q;
  assign bif.mispred_count = mis_cnt_q;

  assign unused_pred_pc = ^{bif.pred_pc[XLEN-1:IDX_W+2], bif.pred_pc[1:0]};
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a one-deep scoreboard queue;
// a second instance with 4-bit statistics shares the same stimulus.
module tb_branch_resolve_unit;
  localparam int XLEN  = 32;
  localparam int IDX_W = 6;

  typedef struct {
    logic        flush;
    logic [31:0] redir;
    logic        bt;
    logic [31:0] bc;
    logic [31:0] mc;
    logic [3:0]  bc4;
    logic [3:0]  mc4;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  exp_t        sb [$];
  logic [1:0]  m_tab [64];
  logic        m_flush, m_bt;
  logic [31:0] m_redir, m_bc, m_mc;

  branch_resolve_if #(.XLEN(XLEN), .CNT_W(32)) bif ();
  branch_resolve_if #(.XLEN(XLEN), .CNT_W(4))  bif4 ();

  assign bif4.pred_pc        = bif.pred_pc;
  assign bif4.res_valid      = bif.res_valid;
  assign bif4.res_ctl        = bif.res_ctl;
  assign bif4.res_a          = bif.res_a;
  assign bif4.res_b          = bif.res_b;
  assign bif4.res_pc         = bif.res_pc;
  assign bif4.res_target     = bif.res_target;
  assign bif4.res_pred_taken = bif.res_pred_taken;
  assign bif4.clr_stats      = bif.clr_stats;

  branch_resolve_unit #(.XLEN(XLEN), .IDX_W(IDX_W), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bif(bif.slave));
  branch_resolve_unit #(.XLEN(XLEN), .IDX_W(IDX_W), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bif(bif4.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {is_branch, taken}
  function automatic logic [1:0] ref_dec(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'b0111: return {1'b1, $signed(a) < $signed(b)};
      4'b1011: return {1'b1, !($signed(a) < $signed(b))};
      4'b1100: return {1'b1, a == b};
      4'b1101: return {1'b1, a != b};
      4'b1000: return {1'b1, a < b};
      4'b1001: return {1'b1, !(a < b)};
      default: return 2'b00;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_tab[i] = 2'b01;
    m_flush = 0; m_bt = 0; m_redir = 0; m_bc = 0; m_mc = 0;
    sb.delete();
  endtask

  task automatic step(input string tag, input logic v, input logic [3:0] ctl,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                      input logic [31:0] tgt, input logic pred, input logic clr);
    logic [1:0] d;
    logic [5:0] idx;
    exp_t e;
    exp_t got;
    bif.res_valid = v; bif.res_ctl = ctl; bif.res_a = a; bif.res_b = b;
    bif.res_pc = pc; bif.res_target = tgt; bif.res_pred_taken = pred;
    bif.clr_stats = clr; bif.pred_pc = pc;
    #1;
    idx = pc[7:2];
    chk({tag, "/pred_pre"}, {31'd0, bif.pred_taken}, {31'd0, m_tab[idx][1]});
    d = ref_dec(ctl, a, b);
    m_flush = 1'b0;
    if (v && d[1]) begin
      if (d[0] && m_tab[idx] != 2'b11) m_tab[idx] = m_tab[idx] + 2'd1;
      else if (!d[0] && m_tab[idx] != 2'b00) m_tab[idx] = m_tab[idx] - 2'd1;
      m_bt = d[0];
      if (m_bc != '1) m_bc = m_bc + 1;
      if (d[0] != pred) begin
        m_flush = 1'b1;
        m_redir = d[0] ? tgt : pc + 32'd4;
        if (m_mc != '1) m_mc = m_mc + 1;
      end
    end
    if (clr) begin m_bc = 0; m_mc = 0; end
    e.flush = m_flush; e.redir = m_redir; e.bt = m_bt; e.bc = m_bc; e.mc = m_mc;
    e.bc4 = (m_bc > 15) ? 4'd15 : m_bc[3:0];
    e.mc4 = (m_mc > 15) ? 4'd15 : m_mc[3:0];
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({tag, "/flush"},    {31'd0, bif.flush},     {31'd0, got.flush});
    chk({tag, "/redirect"}, bif.redirect_pc,        got.redir);
    chk({tag, "/br_taken"}, {31'd0, bif.br_taken},  {31'd0, got.bt});
    chk({tag, "/br_count"}, bif.br_count,           got.bc);
    chk({tag, "/mis_count"}, bif.mispred_count,     got.mc);
    chk({tag, "/br_count4"}, {28'd0, bif4.br_count}, {28'd0, got.bc4});
    chk({tag, "/mis_count4"}, {28'd0, bif4.mispred_count}, {28'd0, got.mc4});
    bif.res_valid = 1'b0;
    bif.clr_stats = 1'b0;
  endtask

  task automatic pred_at(input string tag, input logic [31:0] pc, input logic exp);
    bif.pred_pc = pc;
    #1;
    chk(tag, {31'd0, bif.pred_taken}, {31'd0, exp});
  endtask

  logic [3:0] codes [6];
  logic [1:0] dd;
  logic [3:0] rc;
  logic [31:0] ra, rb;

  initial begin
    codes = '{4'b0111, 4'b1011, 4'b1100, 4'b1101, 4'b1000, 4'b1001};
    model_reset();
    bif.pred_pc = 0; bif.res_valid = 0; bif.res_ctl = 0; bif.res_a = 0; bif.res_b = 0;
    bif.res_pc = 0; bif.res_target = 0; bif.res_pred_taken = 0; bif.clr_stats = 0;
    #2;
    chk("rst/flush", {31'd0, bif.flush}, 32'd0);
    chk("rst/redirect", bif.redirect_pc, 32'd0);
    chk("rst/br_taken", {31'd0, bif.br_taken}, 32'd0);
    chk("rst/br_count", bif.br_count, 32'd0);
    chk("rst/mis_count", bif.mispred_count, 32'd0);
    pred_at("rst/pred_00", 32'h00, 1'b0);
    pred_at("rst/pred_04", 32'h04, 1'b0);
    pred_at("rst/pred_fc", 32'hFC, 1'b0);
    #7 rst_n = 1'b1;
    @(posedge clk); #1;

    // signed versus unsigned compare
    step("blt",  1, 4'b0111, 32'hFFFFFFFF, 32'd1, 32'h10, 32'h500, 0, 0);
    step("bltu", 1, 4'b1000, 32'hFFFFFFFF, 32'd1, 32'h14, 32'h500, 0, 0);
    step("bge",  1, 4'b1011, 32'hFFFFFFFF, 32'd1, 32'h18, 32'h500, 0, 0);
    step("bgeu", 1, 4'b1001, 32'hFFFFFFFF, 32'd1, 32'h1C, 32'h500, 0, 0);
    step("beq",  1, 4'b1100, 32'd5, 32'd5, 32'h20, 32'h500, 1, 0);
    step("bne",  1, 4'b1101, 32'd5, 32'd5, 32'h24, 32'h500, 0, 0);

    // training and saturation at 0x40
    for (int i = 0; i < 4; i++) begin
      step("train_t", 1, 4'b1100, 32'd0, 32'd0, 32'h40, 32'h80, m_tab[16][1], 0);
      pred_at("train_t/pred_post", 32'h40, 1'b1);
    end
    pred_at("train/pc_lowbits", 32'h43, 1'b1);
    step("train_n1", 1, 4'b1101, 32'd0, 32'd0, 32'h40, 32'h80, 1, 0);
    pred_at("train_n1/pred_post", 32'h40, 1'b1);
    step("train_n2", 1, 4'b1101, 32'd0, 32'd0, 32'h40, 32'h80, 1, 0);
    pred_at("train_n2/pred_post", 32'h40, 1'b0);
    step("train_n3", 1, 4'b1101, 32'd0, 32'd0, 32'h40, 32'h80, 0, 0);
    pred_at("train_n3/pred_post", 32'h40, 1'b0);

    // mispredict redirects
    step("mp_taken", 1, 4'b1100, 32'd7, 32'd7, 32'h100, 32'h200, 0, 0);
    chk("mp_taken/redir_const", bif.redirect_pc, 32'h200);
    step("mp_idle", 0, 4'b1100, 32'd7, 32'd7, 32'h100, 32'h200, 0, 0);
    chk("mp_idle/flush_const", {31'd0, bif.flush}, 32'd0);
    step("mp_seq", 1, 4'b1101, 32'd7, 32'd7, 32'h100, 32'h200, 1, 0);
    chk("mp_seq/redir_const", bif.redirect_pc, 32'h104);
    step("mp_wrap", 1, 4'b1101, 32'd7, 32'd7, 32'hFFFFFFFC, 32'h200, 1, 0);
    chk("mp_wrap/redir_const", bif.redirect_pc, 32'h0);

    // not-a-branch code, valid low, clear with mispredict
    step("invalid", 1, 4'b0000, 32'd1, 32'd2, 32'h60, 32'h300, 1, 0);
    step("novalid", 0, 4'b1100, 32'd1, 32'd1, 32'h60, 32'h300, 0, 0);
    step("clr_mp",  1, 4'b1100, 32'd1, 32'd1, 32'h60, 32'h300, 0, 1);
    chk("clr_mp/count_const", bif.br_count, 32'd0);

    // back-to-back mispredicts drive the 4-bit counters into saturation
    for (int i = 0; i < 20; i++) begin
      rc = codes[$urandom_range(0, 5)];
      ra = $urandom_range(0, 3);
      rb = (i % 3 == 0) ? 32'hFFFFFFFE : $urandom_range(0, 3);
      dd = ref_dec(rc, ra, rb);
      step("rand_mp", 1, rc, ra, rb, $urandom, $urandom, !dd[0], 0);
    end
    chk("sat4/br_const", {28'd0, bif4.br_count}, 32'd15);

    // train 0x80 to strong-T, then reset in the middle of a mispredict cycle
    step("pre_rst1", 1, 4'b1100, 32'd0, 32'd0, 32'h80, 32'h400, 0, 0);
    step("pre_rst2", 1, 4'b1100, 32'd0, 32'd0, 32'h80, 32'h400, 1, 0);
    pred_at("pre_rst/pred", 32'h80, 1'b1);
    bif.res_valid = 1; bif.res_ctl = 4'b1100; bif.res_a = 0; bif.res_b = 0;
    bif.res_pc = 32'h80; bif.res_target = 32'h400; bif.res_pred_taken = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst/flush", {31'd0, bif.flush}, 32'd0);
    chk("arst/br_count", bif.br_count, 32'd0);
    chk("arst/mis_count", bif.mispred_count, 32'd0);
    chk("arst/redirect", bif.redirect_pc, 32'd0);
    @(posedge clk); #1;
    chk("arst/flush_hold", {31'd0, bif.flush}, 32'd0);
    bif.res_valid = 0;
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk("arst/flush_after", {31'd0, bif.flush}, 32'd0);
    pred_at("arst/pred_80", 32'h80, 1'b0);
    step("post_rst", 1, 4'b1100, 32'd0, 32'd0, 32'h80, 32'h400, 0, 0);
    pred_at("post_rst/pred_80", 32'h80, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised successor to the single-cycle branch comparator. Resolves conditional branches (signed and unsigned) in the execute stage, holds a direct-mapped table of 2-bit saturating counters for fetch-stage prediction, and raises a registered one-cycle flush with redirect PC when the resolved outcome disagrees with the prediction. Also keeps saturating branch and mispredict statistics counters for the lab performance report.

## Interface
- XLEN, 32, operand/PC width
- IDX_W, 6, table index bits; table has 2^IDX_W entries
- CNT_W, 32, width of statistics counters

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- pred_pc  in  XLEN  fetch-stage PC to predict
- pred_taken  out  1  combinational prediction for pred_pc
- res_valid  in  1  resolve request this cycle
- res_ctl  in  4  branch type
- res_a, res_b  in  XLEN  comparison operands
- res_pc  in  XLEN  PC of resolving branch
- res_target  in  XLEN  taken target address
- res_pred_taken  in  1  prediction originally used for this branch
- clr_stats  in  1  synchronous clear of statistics
- flush  out  1  registered one-cycle mispredict pulse
- redirect_pc  out  XLEN  registered correct next PC, meaningful when flush=1
- br_taken  out  1  registered actual outcome of last valid resolve
- br_count  out  CNT_W  resolved-branch count
- mispred_count  out  CNT_W  mispredict count

## Operation
- Branch types (res_ctl): 4'b0111 BLT signed a<b; 4'b1011 BGE signed !(a<b); 4'b1100 BEQ; 4'b1101 BNE; 4'b1000 BLTU unsigned a<b; 4'b1001 BGEU unsigned !(a<b). Any other code: not a branch.
- A resolve is *effective* when res_valid=1 and res_ctl is one of the six codes; otherwise the block does nothing (no table update, no count, flush=0, br_taken holds).
- Index = pc[IDX_W+1:2] for both predict and resolve; pc[1:0] ignored.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. pred_taken = counter[1] of entry at pred_pc index.
- Update on effective resolve: taken -> +1 saturating at 11; not taken -> -1 saturating at 00.
- Mispredict = actual taken != res_pred_taken. On mispredict: flush=1, redirect_pc = taken ? res_target : res_pc+4 (modulo 2^XLEN, wraps).
- br_count +1 per effective resolve; mispred_count +1 per mispredict; both saturate at all-ones.
- clr_stats=1 zeroes both counters at the edge and overrides any same-cycle increment; table unaffected.

## Timing
- Reset (async, rst_n=0): every table entry = 01, flush=0, redirect_pc=0, br_taken=0, br_count=0, mispred_count=0. Asserting rst_n mid-operation discards any pending update and clears outputs immediately, not at the next edge.
- Prediction: zero latency, combinational from pred_pc and current table.
- Resolve in cycle N (sampled at rising edge ending N): table entry, br_taken, flush, redirect_pc, and counters take new values at that edge, visible throughout cycle N+1.
- flush is high for exactly one cycle per mispredict; back-to-back mispredicts in N and N+1 give flush high in N+1 and N+2 with each cycle's own redirect_pc.
- Same-cycle predict and resolve to the same index: pred_taken shows the pre-update value (no bypass); new value visible from N+1.
- Back-to-back resolves to the same index accumulate (two takens from 01 reach 11).
- redirect_pc holds its last value when flush=0.

## Test plan
- Reset: rst_n low -> all outputs 0; pred_taken=0 for pred_pc 0x00, 0x04, 0xFC.
- Signed vs unsigned: a=0xFFFFFFFF, b=1: BLT taken, BLTU not taken, BGE not taken, BGEU taken; BEQ a=b=5 taken, BNE not taken; br_taken matches each next cycle.
- Training/saturation: pc=0x40, four taken resolves -> counter 10,11,11,11, pred_taken=1 from cycle after first; three not-taken -> 10,01,00, pred_taken=0 after second.
- Mispredict redirect: res_pc=0x100, target=0x200, pred=0, BEQ a=b -> flush=1 for one cycle, redirect_pc=0x200; same with BNE a=b, pred=1 -> redirect_pc=0x104; pc=0xFFFFFFFC not-taken mispredict -> redirect 0x0.
- Invalid/stats: res_ctl=4'b0000 with res_valid=1 -> no flush, counts unchanged; clr_stats with simultaneous mispredict -> both counts 0; counters with CNT_W=4 stop at 15.
- Async reset mid-stream: rst_n low during a mispredict cycle -> flush stays 0, table back to 01, counts 0.
